// File: rtl/pid_gain_sequencer.sv
// Sequences the PID core's reset and gain-code capture over the shared setpoint bus,
// then hands the bus to the live setpoint until the next apply.
module pid_gain_sequencer #(
   parameter int         RST_CYCLES = 2,
   parameter logic [3:0] DEF_KP     = 4'd10,
   parameter logic [3:0] DEF_KI     = 4'd0,
   parameter logic [3:0] DEF_KD     = 4'd0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_we,
   input  logic [1:0] cfg_addr,
   input  logic [3:0] cfg_wdata,
   input  logic       apply,
   input  logic [7:0] live_setpoint,
   output logic       pid_rst_n,
   output logic [7:0] pid_setpoint,
   output logic       busy,
   output logic       running,
   output logic       done
);

   localparam int            CW       = $clog2(RST_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(RST_CYCLES - 1);

   typedef enum logic [2:0] {
      RESET_PID,
      SEND_KP,
      SEND_KI,
      SEND_KD,
      RUN
   } state_t;

   state_t        state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          pending, pending_d;
   logic          copy;

   logic [3:0] shadow_kp, shadow_ki, shadow_kd;
   logic [3:0] active_kp, active_ki, active_kd;
   logic [3:0] shadow_kp_w, shadow_ki_w, shadow_kd_w;

   logic       pid_rst_n_d;
   logic [7:0] pid_setpoint_d;
   logic       busy_d, running_d, done_d;

   // Post-write shadow values, so a write and apply in one cycle copies the new code
   always_comb begin
      shadow_kp_w = shadow_kp;
      shadow_ki_w = shadow_ki;
      shadow_kd_w = shadow_kd;
      if (cfg_we) begin
         case (cfg_addr)
            2'd0:    shadow_kp_w = cfg_wdata;
            2'd1:    shadow_ki_w = cfg_wdata;
            2'd2:    shadow_kd_w = cfg_wdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= RESET_PID;
         cnt          <= '0;
         pending      <= 1'b0;
         shadow_kp    <= DEF_KP;
         shadow_ki    <= DEF_KI;
         shadow_kd    <= DEF_KD;
         active_kp    <= DEF_KP;
         active_ki    <= DEF_KI;
         active_kd    <= DEF_KD;
         pid_rst_n    <= 1'b0;
         pid_setpoint <= 8'h00;
         busy         <= 1'b1;
         running      <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         pending      <= pending_d;
         shadow_kp    <= shadow_kp_w;
         shadow_ki    <= shadow_ki_w;
         shadow_kd    <= shadow_kd_w;
         if (copy) begin
            active_kp <= shadow_kp_w;
            active_ki <= shadow_ki_w;
            active_kd <= shadow_kd_w;
         end
         pid_rst_n    <= pid_rst_n_d;
         pid_setpoint <= pid_setpoint_d;
         busy         <= busy_d;
         running      <= running_d;
         done         <= done_d;
      end
   end

   // An apply arriving in SEND_KD counts as pending so it is never stranded in RUN
   always_comb begin
      state_d   = state;
      pending_d = pending;
      copy      = 1'b0;
      case (state)
         RESET_PID: begin
            pending_d = pending | apply;
            if (cnt == CNT_LAST)
               state_d = SEND_KP;
         end
         SEND_KP: begin
            pending_d = pending | apply;
            state_d   = SEND_KI;
         end
         SEND_KI: begin
            pending_d = pending | apply;
            state_d   = SEND_KD;
         end
         SEND_KD: begin
            if (pending | apply) begin
               state_d   = RESET_PID;
               copy      = 1'b1;
               pending_d = 1'b0;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (apply) begin
               state_d = RESET_PID;
               copy    = 1'b1;
            end
         end
         default: state_d = RESET_PID;
      endcase
      cnt_d = (state == RESET_PID && state_d == RESET_PID) ? cnt + CW'(1) : '0;
   end

   // Outputs are decoded from the next state and registered alongside it
   always_comb begin
      pid_rst_n_d    = 1'b1;
      pid_setpoint_d = 8'h00;
      busy_d         = 1'b1;
      running_d      = 1'b0;
      done_d         = 1'b0;
      case (state_d)
         RESET_PID: pid_rst_n_d    = 1'b0;
         SEND_KP:   pid_setpoint_d = {4'h0, active_kp};
         SEND_KI:   pid_setpoint_d = {4'h0, active_ki};
         SEND_KD:   pid_setpoint_d = {4'h0, active_kd};
         RUN: begin
            pid_setpoint_d = live_setpoint;
            busy_d         = 1'b0;
            running_d      = 1'b1;
            done_d         = (state != RUN);
         end
         default: pid_rst_n_d = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_pid_gain_sequencer.sv
// Scoreboard bench for pid_gain_sequencer: a position-based reference model predicts
// every post-edge output, and a monitor compares one cycle's prediction per clock.
module tb_pid_gain_sequencer;

   localparam int R      = 2;
   localparam int RUNPOS = R + 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = 2'd0;
   logic [3:0] cfg_wdata = 4'd0;
   logic       apply = 1'b0;
   logic [7:0] live_setpoint = 8'h00;
   logic       pid_rst_n;
   logic [7:0] pid_setpoint;
   logic       busy, running, done;

   pid_gain_sequencer #(
      .RST_CYCLES(R),
      .DEF_KP(4'd10),
      .DEF_KI(4'd0),
      .DEF_KD(4'd0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cfg_we(cfg_we),
      .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata),
      .apply(apply),
      .live_setpoint(live_setpoint),
      .pid_rst_n(pid_rst_n),
      .pid_setpoint(pid_setpoint),
      .busy(busy),
      .running(running),
      .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rst;
      logic [7:0] sp;
      logic       busy;
      logic       running;
      logic       done;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   // Reference model: position 0..R-1 is reset, R..R+2 sends Kp/Ki/Kd, RUNPOS is run
   int         m_pos;
   logic [3:0] m_shadow[3];
   logic [3:0] m_active[3];
   logic       m_pending;
   logic [7:0] cur_live = 8'h00;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelReset();
      m_pos       = 0;
      m_shadow[0] = 4'd10; m_shadow[1] = 4'd0; m_shadow[2] = 4'd0;
      m_active    = m_shadow;
      m_pending   = 1'b0;
   endfunction

   function automatic exp_t modelStep(input logic we, input logic [1:0] addr,
                                      input logic [3:0] wd, input logic ap,
                                      input logic [7:0] live);
      logic [3:0] sh[3];
      int         old_pos;
      exp_t       e;
      old_pos = m_pos;
      sh      = m_shadow;
      if (we && addr != 2'd3) sh[addr] = wd;
      if (m_pos == RUNPOS) begin
         if (ap) begin
            m_active = sh;
            m_pos    = 0;
         end
      end else if (m_pos == R + 2) begin
         if (m_pending || ap) begin
            m_active  = sh;
            m_pending = 1'b0;
            m_pos     = 0;
         end else begin
            m_pos = RUNPOS;
         end
      end else begin
         m_pending = m_pending | ap;
         m_pos++;
      end
      m_shadow = sh;
      e.rst     = (m_pos >= R);
      if (m_pos < R)           e.sp = 8'h00;
      else if (m_pos < R + 3)  e.sp = {4'h0, m_active[m_pos-R]};
      else                     e.sp = live;
      e.busy    = (m_pos != RUNPOS);
      e.running = (m_pos == RUNPOS);
      e.done    = (m_pos == RUNPOS) && (old_pos != RUNPOS);
      return e;
   endfunction

   // Called at a falling edge: drives one cycle of inputs, predicts, waits for next fall
   task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [3:0] wd,
                                input logic ap, input logic [7:0] live);
      cfg_we        = we;
      cfg_addr      = addr;
      cfg_wdata     = wd;
      apply         = ap;
      live_setpoint = live;
      cur_live      = live;
      sb.push_back(modelStep(we, addr, wd, ap, live));
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, cur_live);
   endtask

   task automatic runUntil(input int target);
      int k;
      k = 0;
      while (m_pos != target && k < 50) begin
         idle(1);
         k++;
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_pid_rst_n"}, {7'd0, pid_rst_n}, 8'h00);
      checkOutput({tag, "_pid_setpoint"}, pid_setpoint, 8'h00);
      checkOutput({tag, "_busy"}, {7'd0, busy}, 8'h01);
      checkOutput({tag, "_running"}, {7'd0, running}, 8'h00);
      checkOutput({tag, "_done"}, {7'd0, done}, 8'h00);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("pid_rst_n", {7'd0, pid_rst_n}, {7'd0, e.rst});
            checkOutput("pid_setpoint", pid_setpoint, e.sp);
            checkOutput("busy", {7'd0, busy}, {7'd0, e.busy});
            checkOutput("running", {7'd0, running}, {7'd0, e.running});
            checkOutput("done", {7'd0, done}, {7'd0, e.done});
         end
      end
   end

   initial begin : stimulus
      modelReset();
      #12;
      checkResetValues("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Power-up sequence with default codes, then live 0x40 in RUN
      idle(0);
      applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 8'h40);
      idle(8);

      // New gains written in RUN, then applied
      applyStimulus(1'b1, 2'd0, 4'd3, 1'b0, 8'h40);
      applyStimulus(1'b1, 2'd1, 4'd1, 1'b0, 8'h40);
      applyStimulus(1'b1, 2'd2, 4'd2, 1'b0, 8'h40);
      applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 8'h40);
      idle(8);

      // Write-through on same-cycle apply; addr 3 write during the sequence is dropped
      applyStimulus(1'b1, 2'd1, 4'd7, 1'b1, 8'h40);
      applyStimulus(1'b1, 2'd3, 4'd9, 1'b0, 8'h40);
      idle(8);

      // Applies during SEND_KI and SEND_KD merge into one extra sequence
      applyStimulus(1'b1, 2'd0, 4'd5, 1'b1, 8'h40);
      runUntil(R + 1);
      applyStimulus(1'b1, 2'd2, 4'd12, 1'b1, 8'h40);
      applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 8'h40);
      idle(10);

      // Writes in RUN without apply, live setpoint change, then apply
      applyStimulus(1'b1, 2'd0, 4'd14, 1'b0, 8'h10);
      applyStimulus(1'b1, 2'd2, 4'd6, 1'b0, 8'h10);
      applyStimulus(1'b0, 2'd0, 4'd0, 1'b0, 8'hF0);
      idle(3);
      applyStimulus(1'b0, 2'd0, 4'd0, 1'b1, 8'hF0);
      idle(8);

      // Asynchronous reset during SEND_KP, restart uses default codes
      applyStimulus(1'b1, 2'd0, 4'd4, 1'b1, 8'h22);
      runUntil(R);
      rst_n = 1'b0;
      #1;
      checkResetValues("async_rst");
      modelReset();
      @(negedge clk);
      checkResetValues("rst_hold");
      rst_n = 1'b1;
      idle(8);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         applyStimulus(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                       4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0),
                       8'($urandom_range(0, 255)));
      end
      idle(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
